// File: rtl/axi_interconnect_define.sv
// rtl/axi_interconnect_define.sv - shared state encodings and sizing helpers for the crossbar write grant path
package axi_interconnect_define;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } wr_state_t;

   // Watchdog counter width; must hold TIMEOUT-1.
   function automatic int timeout_cnt_width(input int timeout);
      return (timeout > 2) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
// rtl/axi_interconnect_crossbar_arbit_polling.sv - round-robin polling arbiter, search starts at last_user+1
module axi_interconnect_crossbar_arbit_polling #(
   parameter int NUM   = 8,
   parameter int WIDTH = $clog2(NUM)
) (
   input  logic [NUM-1:0]   user_req,
   input  logic [WIDTH-1:0] last_user,
   output logic [WIDTH-1:0] current_user
);

   logic [WIDTH-1:0] w_idx;
   logic             w_found;

   // i == NUM lands back on last_user, so a lone repeat requester wins again.
   always_comb begin
      current_user = last_user;
      w_idx        = '0;
      w_found      = 1'b0;
      for (int i = 1; i <= NUM; i++) begin
         w_idx = WIDTH'((int'(last_user) + i) % NUM);
         if (!w_found && user_req[w_idx]) begin
            current_user = w_idx;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_interconnect_crossbar_wr_grant.sv
// rtl/axi_interconnect_crossbar_wr_grant.sv - per-slave write grant FSM; optional watchdog under AXI_XBAR_WR_TIMEOUT_EN
module axi_interconnect_crossbar_wr_grant
   import axi_interconnect_define::*;
#(
   parameter int NUM     = 8,
   parameter int WIDTH   = $clog2(NUM),
   parameter int TIMEOUT = 1024
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic [NUM-1:0]   m_awvalid,
   output logic [NUM-1:0]   m_awready,
   output logic             s_awvalid,
   input  logic             s_awready,
   input  logic [NUM-1:0]   m_wvalid,
   input  logic [NUM-1:0]   m_wlast,
   output logic [NUM-1:0]   m_wready,
   output logic             s_wvalid,
   output logic             s_wlast,
   input  logic             s_wready,
   input  logic             s_bvalid,
   output logic             s_bready,
   output logic [NUM-1:0]   m_bvalid,
   input  logic [NUM-1:0]   m_bready,
   output logic             grant_vld,
   output logic [WIDTH-1:0] grant_user,
   output logic [WIDTH-1:0] last_user,
   output logic             timeout_err
);

   wr_state_t        r_state;
   logic             r_grant_vld;
   logic [WIDTH-1:0] r_grant_user;
   logic [WIDTH-1:0] r_last_user;
   logic             r_timeout_err;
   logic [WIDTH-1:0] w_current_user;
   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_b_hs;
   logic             w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT == 0);

   axi_interconnect_crossbar_arbit_polling #(
      .NUM   (NUM),
      .WIDTH (WIDTH)
   ) u_arbit (
      .user_req     (m_awvalid),
      .last_user    (r_last_user),
      .current_user (w_current_user)
   );

   // Channel routing is decoded from registered state so nothing leaks outside its phase.
   always_comb begin
      m_awready = '0;
      s_awvalid = 1'b0;
      m_wready  = '0;
      s_wvalid  = 1'b0;
      s_wlast   = 1'b0;
      m_bvalid  = '0;
      s_bready  = 1'b0;
      case (r_state)
         ST_ADDR: begin
            s_awvalid               = m_awvalid[r_grant_user];
            m_awready[r_grant_user] = s_awready;
         end
         ST_DATA: begin
            s_wvalid               = m_wvalid[r_grant_user];
            s_wlast                = m_wlast[r_grant_user];
            m_wready[r_grant_user] = s_wready;
         end
         ST_RESP: begin
            m_bvalid[r_grant_user] = s_bvalid;
            s_bready               = m_bready[r_grant_user];
         end
         default: ;
      endcase
   end

   assign w_aw_hs = s_awvalid & s_awready;
   assign w_w_hs  = s_wvalid & s_wready;
   assign w_b_hs  = s_bvalid & s_bready;

`ifdef AXI_XBAR_WR_TIMEOUT_EN
   localparam int TW = timeout_cnt_width(TIMEOUT);
   logic [TW-1:0] r_cnt;
`endif

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_grant_vld   <= 1'b0;
         r_grant_user  <= '0;
         r_last_user   <= '0;
         r_timeout_err <= 1'b0;
`ifdef AXI_XBAR_WR_TIMEOUT_EN
         r_cnt         <= '0;
`endif
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|m_awvalid) begin
                  r_state      <= ST_ADDR;
                  r_grant_user <= w_current_user;
                  r_grant_vld  <= 1'b1;
               end
            end
            ST_ADDR: if (w_aw_hs) r_state <= ST_DATA;
            ST_DATA: if (w_w_hs && s_wlast) r_state <= ST_RESP;
            ST_RESP: begin
               if (w_b_hs) begin
                  r_state     <= ST_IDLE;
                  r_last_user <= r_grant_user;
                  r_grant_vld <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
`ifdef AXI_XBAR_WR_TIMEOUT_EN
         // A handshake always beats the watchdog, so the late assignments below never fight a transition.
         if (r_state == ST_DATA || r_state == ST_RESP) begin
            if (w_w_hs || w_b_hs) begin
               r_cnt <= '0;
            end else if (r_cnt == TW'(TIMEOUT - 1)) begin
               r_cnt         <= '0;
               r_timeout_err <= 1'b1;
               r_state       <= ST_IDLE;
               r_last_user   <= r_grant_user;
               r_grant_vld   <= 1'b0;
            end else begin
               r_cnt <= r_cnt + TW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
`endif
      end
   end

   assign grant_vld   = r_grant_vld;
   assign grant_user  = r_grant_user;
   assign last_user   = r_last_user;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_axi_interconnect_crossbar_wr_grant.sv
// tb/tb_axi_interconnect_crossbar_wr_grant.sv - directed self-checking bench for the write grant controller
module tb_axi_interconnect_crossbar_wr_grant;

   logic       clk_sys = 1'b0;
   logic       rst_n;
   logic [7:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
   logic       s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
   logic       grant_vld, timeout_err;
   logic [2:0] grant_user, last_user;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk_sys = ~clk_sys;

   axi_interconnect_crossbar_wr_grant #(.NUM(8), .WIDTH(3), .TIMEOUT(16)) u_dut (
      .clk_sys     (clk_sys),
      .rst_n       (rst_n),
      .m_awvalid   (m_awvalid),
      .m_awready   (m_awready),
      .s_awvalid   (s_awvalid),
      .s_awready   (s_awready),
      .m_wvalid    (m_wvalid),
      .m_wlast     (m_wlast),
      .m_wready    (m_wready),
      .s_wvalid    (s_wvalid),
      .s_wlast     (s_wlast),
      .s_wready    (s_wready),
      .s_bvalid    (s_bvalid),
      .s_bready    (s_bready),
      .m_bvalid    (m_bvalid),
      .m_bready    (m_bready),
      .grant_vld   (grant_vld),
      .grant_user  (grant_user),
      .last_user   (last_user),
      .timeout_err (timeout_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge with the FSM in ADDR; leaves at the IDLE bubble negedge.
   task automatic run_txn(input int g, input int beats);
      logic [7:0] oh;
      oh = 8'(1) << g;
      check_eq("aw_grant_vld", grant_vld, 1);
      check_eq("aw_grant_user", grant_user, g);
      check_eq("aw_s_awvalid", s_awvalid, 1);
      check_eq("aw_m_awready_wait", m_awready, 0);
      s_awready = 1'b1;
      #1 check_eq("aw_m_awready", m_awready, oh);
      @(negedge clk_sys);
      s_awready = 1'b0;
      #1 check_eq("w_s_awvalid", s_awvalid, 0);
      for (int b = 0; b < beats; b++) begin
         m_wvalid = oh;
         m_wlast  = (b == beats - 1) ? oh : 8'h00;
         s_wready = 1'b1;
         #1;
         check_eq("w_m_wready", m_wready, oh);
         check_eq("w_s_wvalid", s_wvalid, 1);
         check_eq("w_s_wlast", s_wlast, (b == beats - 1) ? 1 : 0);
         @(negedge clk_sys);
      end
      m_wvalid = '0;
      m_wlast  = '0;
      s_wready = 1'b0;
      m_bready = oh;
      #1;
      check_eq("b_m_wready", m_wready, 0);
      check_eq("b_m_bvalid_wait", m_bvalid, 0);
      check_eq("b_s_bready", s_bready, 1);
      s_bvalid = 1'b1;
      #1 check_eq("b_m_bvalid", m_bvalid, oh);
      @(negedge clk_sys);
      s_bvalid = 1'b0;
      m_bready = '0;
      #1;
      check_eq("end_grant_vld", grant_vld, 0);
      check_eq("end_last_user", last_user, g);
      check_eq("end_s_awvalid", s_awvalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
      repeat (2) @(negedge clk_sys);
      check_eq("rst_grant_vld", grant_vld, 0);
      check_eq("rst_grant_user", grant_user, 0);
      check_eq("rst_last_user", last_user, 0);
      check_eq("rst_timeout_err", timeout_err, 0);
      check_eq("rst_s_awvalid", s_awvalid, 0);
      check_eq("rst_s_bready", s_bready, 0);

      // Single requester straight out of reset.
      rst_n = 1'b1;
      m_awvalid = 8'h01;
      @(negedge clk_sys);
      run_txn(0, 1);
      m_awvalid = 8'h00;

      // Round robin 2 -> 7 -> 2 with both requests held throughout.
      m_awvalid = 8'h84;
      @(negedge clk_sys);
      run_txn(2, 1);
      @(negedge clk_sys);
      run_txn(7, 1);
      @(negedge clk_sys);
      run_txn(2, 1);
      m_awvalid = 8'h00;

      // Four-beat burst from master 3.
      m_awvalid = 8'h08;
      @(negedge clk_sys);
      run_txn(3, 4);
      m_awvalid = 8'h00;

      // Master 5 presents W ahead of its AW grant.
      m_awvalid = 8'h20; m_wvalid = 8'h20; m_wlast = 8'h20; s_wready = 1'b1;
      #1 check_eq("early_w_idle_wready", m_wready, 0);
      @(negedge clk_sys);
      check_eq("early_w_addr_wready", m_wready, 0);
      check_eq("early_w_addr_swvalid", s_wvalid, 0);
      run_txn(5, 1);
      m_awvalid = 8'h00;

      // Reset during DATA aborts with no B.
      m_awvalid = 8'h02;
      @(negedge clk_sys);
      s_awready = 1'b1;
      @(negedge clk_sys);
      s_awready = 1'b0;
      m_wvalid = 8'h02; s_wready = 1'b1;
      #1 check_eq("mid_m_wready", m_wready, 8'h02);
      rst_n = 1'b0;
      @(negedge clk_sys);
      check_eq("mid_rst_grant_vld", grant_vld, 0);
      check_eq("mid_rst_grant_user", grant_user, 0);
      check_eq("mid_rst_last_user", last_user, 0);
      check_eq("mid_rst_m_wready", m_wready, 0);
      check_eq("mid_rst_s_awvalid", s_awvalid, 0);
      check_eq("mid_rst_m_bvalid", m_bvalid, 0);
      m_awvalid = 8'h00; m_wvalid = 8'h00; s_wready = 1'b0;
      rst_n = 1'b1;

      // Stalled slave in DATA: watchdog fires after 16 cycles when compiled in.
      m_awvalid = 8'h50;
      @(negedge clk_sys);
      check_eq("to_grant_user", grant_user, 4);
      s_awready = 1'b1;
      @(negedge clk_sys);
      s_awready = 1'b0;
      m_wvalid = 8'h10;
      for (int c = 0; c < 16; c++) begin
         check_eq("to_quiet", timeout_err, 0);
         @(negedge clk_sys);
      end
`ifdef AXI_XBAR_WR_TIMEOUT_EN
      check_eq("to_pulse", timeout_err, 1);
      check_eq("to_grant_vld", grant_vld, 0);
      check_eq("to_last_user", last_user, 4);
      @(negedge clk_sys);
      check_eq("to_pulse_end", timeout_err, 0);
      check_eq("to_next_grant_vld", grant_vld, 1);
      check_eq("to_next_grant_user", grant_user, 6);
`else
      check_eq("hold_timeout_err", timeout_err, 0);
      check_eq("hold_grant_vld", grant_vld, 1);
      check_eq("hold_grant_user", grant_user, 4);
`endif
      m_awvalid = 8'h00; m_wvalid = 8'h00;
      rst_n = 1'b0;
      @(negedge clk_sys);
      check_eq("final_grant_vld", grant_vld, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
